// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event decoder: FSM state codes and
// millisecond-to-clock-cycle conversion.
package btn_event_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 32;

  localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
  localparam logic [STATE_W-1:0] ST_HELD        = 3'd1;
  localparam logic [STATE_W-1:0] ST_LONG_HELD   = 3'd2;
  localparam logic [STATE_W-1:0] ST_GAP         = 3'd3;
  localparam logic [STATE_W-1:0] ST_SECOND_HELD = 3'd4;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 32'd1000) * ms;
  endfunction

endpackage

// File: rtl/button_event_decoder.sv
// Decodes a clean button level into press/release/long-press and
// single/double-click pulses.
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter int unsigned DOUBLE_GAP_MS = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic single_click,
  output logic double_click
);

  localparam int unsigned LONG_CNT = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
  localparam int unsigned GAP_CNT  = ms_to_cycles(CLK_FREQ, DOUBLE_GAP_MS);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 32'd1);

  generate
    if (LONG_CNT < 2 || GAP_CNT < 2) begin : g_bad_cfg
      $error("button_event_decoder: LONG_CNT and GAP_CNT must both be >= 2");
    end
  endgenerate

  logic [STATE_W-1:0] state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               btn_prev;
  logic               rise, fall;
  logic               press_nxt, release_nxt, long_nxt, single_nxt, double_nxt;

  assign rise = btn_in & ~btn_prev;
  assign fall = ~btn_in & btn_prev;

  // State, counter, edge history and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      btn_prev      <= btn_in;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      single_click  <= 1'b0;
      double_click  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_prev      <= btn_in;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      single_click  <= single_nxt;
      double_click  <= double_nxt;
    end
  end

  // Next state; the counter defaults to 0 so every state entry clears it,
  // and edges are tested before expiry so they win on coincidence.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    single_nxt  = 1'b0;
    double_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          press_nxt = 1'b1;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = ST_GAP;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = ST_LONG_HELD;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_LONG_HELD: begin
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (rise) begin
          press_nxt  = 1'b1;
          double_nxt = 1'b1;
          state_nxt  = ST_SECOND_HELD;
        end else if (cnt == GAP_LAST) begin
          single_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SECOND_HELD: begin
        if (fall) begin
          release_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized scoreboard bench for button_event_decoder: a deadline-based
// reference model predicts every pulse, a monitor compares each cycle.
module tb_button_event_decoder;

  localparam int unsigned LONG = 20;
  localparam int unsigned GAP  = 10;

  localparam logic [4:0] M_P = 5'b00001;
  localparam logic [4:0] M_R = 5'b00010;
  localparam logic [4:0] M_L = 5'b00100;
  localparam logic [4:0] M_S = 5'b01000;
  localparam logic [4:0] M_D = 5'b10000;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic press_pulse, release_pulse, long_pulse, single_click, double_click;

  bit   rst_seq[$];
  bit   lvl_seq[$];
  ev_t  exp_q[$];
  int   cyc = 0;
  int   n_edges = 0;
  int   total = 0;
  int   bad = 0;

  button_event_decoder #(
    .CLK_FREQ(1000),
    .LONG_PRESS_MS(20),
    .DOUBLE_GAP_MS(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .single_click(single_click),
    .double_click(double_click)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic seg(input bit r, input bit l, input int len);
    for (int i = 0; i < len; i++) begin
      rst_seq.push_back(r);
      lvl_seq.push_back(l);
    end
  endtask

  // Reference: each press/release opens a deadline; an edge arriving on or
  // before the deadline takes precedence over the deadline itself.
  task automatic run_model();
    int  mode = 0;  // 0 idle, 1 first press, 2 long hold, 3 waiting gap, 4 second press
    int  deadline = 0;
    bit  prev = 1'b0;
    for (int n = 1; n < rst_seq.size(); n++) begin
      bit         up, down;
      logic [4:0] m;
      if (rst_seq[n]) begin
        mode = 0;
        prev = lvl_seq[n];
        continue;
      end
      up   = lvl_seq[n] && !prev;
      down = !lvl_seq[n] && prev;
      prev = lvl_seq[n];
      m    = '0;
      case (mode)
        0: if (up) begin m = M_P; mode = 1; deadline = n + LONG; end
        1: if (down) begin m = M_R; mode = 3; deadline = n + GAP; end
           else if (n == deadline) begin m = M_L; mode = 2; end
        2: if (down) begin m = M_R; mode = 0; end
        3: if (up) begin m = M_P | M_D; mode = 4; end
           else if (n == deadline) begin m = M_S; mode = 0; end
        default: if (down) begin m = M_R; mode = 0; end
      endcase
      if (m != '0) exp_q.push_back('{cyc: n, mask: m});
    end
  endtask

  // Monitor: outputs produced by edge cyc, compared against the scoreboard
  always @(negedge clk) begin
    if (cyc > 0 && cyc <= n_edges) begin
      logic [4:0] obs, want;
      obs  = {double_click, single_click, long_pulse, release_pulse, press_pulse};
      want = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) want = exp_q.pop_front().mask;
      total++;
      if (obs !== want) begin
        bad++;
        if (bad <= 30)
          $display("FAIL pulses cycle=%0d got=%b want=%b (dclk,sclk,long,rel,press)",
                   cyc, obs, want);
      end
    end
  end

  initial begin
    bit l;
    rst_seq.push_back(1'b0);  // index 0 unused: index == edge number
    lvl_seq.push_back(1'b0);
    // button held through reset release: no press expected
    seg(1, 1, 3); seg(0, 1, 5); seg(0, 0, 15);
    // single click
    seg(0, 1, 5); seg(0, 0, 15);
    // double click
    seg(0, 1, 5); seg(0, 0, 4); seg(0, 1, 5); seg(0, 0, 15);
    // long press
    seg(0, 1, 30); seg(0, 0, 15);
    // fall coincides with long expiry
    seg(0, 1, 20); seg(0, 0, 15);
    // rise coincides with gap expiry
    seg(0, 1, 5); seg(0, 0, 10); seg(0, 1, 5); seg(0, 0, 15);
    // reset during gap, then reset during a long hold
    seg(0, 1, 5); seg(0, 0, 3); seg(1, 0, 2); seg(0, 0, 15);
    seg(0, 1, 25); seg(1, 1, 1); seg(0, 1, 10); seg(0, 0, 15);
    // random segments, biased towards the boundary lengths
    l = 1'b0;
    for (int i = 0; i < 80; i++) begin
      int len;
      case ($urandom_range(0, 6))
        0: len = 10;
        1: len = 11;
        2: len = 20;
        3: len = 21;
        default: len = int'($urandom_range(1, 35));
      endcase
      if ($urandom_range(0, 14) == 0) begin
        seg(1, l, int'($urandom_range(1, 3)));
      end else begin
        l = ~l;
        seg(0, l, len);
      end
    end
    seg(0, 0, 25);

    run_model();
    n_edges = rst_seq.size() - 1;

    rst    = rst_seq[1];
    btn_in = lvl_seq[1];
    for (int n = 2; n <= n_edges; n++) begin
      @(negedge clk);
      rst    = rst_seq[n];
      btn_in = lvl_seq[n];
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
